// File: rtl/pe_row_ctrl_if.sv
// Pixel-stream and psum-stream handshake bundle between pe_row_ctrl and its neighbours.
// master = the row controller, slave = pixel buffer / psum collector side.
interface pe_row_ctrl_if;
    logic pix_valid;
    logic pix_ready;
    logic pe_en;
    logic psum_valid;
    logic psum_ready;

    modport master (
        input  pix_valid,
        output pix_ready,
        output pe_en,
        output psum_valid,
        input  psum_ready
    );

    modport slave (
        output pix_valid,
        input  pix_ready,
        input  pe_en,
        input  psum_valid,
        output psum_ready
    );
endinterface

// File: rtl/pe_row_ctrl.sv
// Sequences one 16-PE systolic row through a 1-D convolution pass (load weights, pre-fill, stream).
// Optional stall counter enabled by defining PE_ROW_CTRL_PERF_EN.
module pe_row_ctrl #(
    parameter int KSIZE      = 3,
    parameter int CNT_W      = 8,
    parameter int CAST_LANES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           cfg_mode,
    input  logic [CNT_W-1:0]     cfg_cols,
    pe_row_ctrl_if.master        bus,
    output logic                 wgt_load,
    output logic [1:0]           pe_mode,
    output logic [1:0]           cast_sel,
    output logic [CNT_W-1:0]     col_cnt,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          stall_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_FILL   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int FILL_W = (KSIZE > 2) ? $clog2(KSIZE) : 1;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cols_q;
    logic [CNT_W-1:0]  px_cnt;
    logic [FILL_W-1:0] fill_cnt;
    logic [1:0]        lane;
    logic              psum_valid_q;
    logic              pix_ready_c;
    logic              pix_hs;
    logic              psum_hs;

    // In RUN a pending, unaccepted psum blocks the next pixel so no column is lost.
    always_comb begin
        pix_ready_c = 1'b0;
        case (state)
            S_FILL:  pix_ready_c = 1'b1;
            S_RUN:   pix_ready_c = !(psum_valid_q && !bus.psum_ready);
            default: pix_ready_c = 1'b0;
        endcase
    end

    assign pix_hs         = bus.pix_valid && pix_ready_c;
    assign psum_hs        = psum_valid_q && bus.psum_ready;
    assign bus.pix_ready  = pix_ready_c;
    assign bus.pe_en      = pix_hs;
    assign bus.psum_valid = psum_valid_q;
    assign wgt_load       = (state == S_LOAD_W);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign cast_sel       = (state == S_RUN && pe_mode == 2'b01) ? lane : 2'd3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            pe_mode      <= 2'b00;
            cols_q       <= '0;
            px_cnt       <= '0;
            fill_cnt     <= '0;
            lane         <= 2'd0;
            psum_valid_q <= 1'b0;
            col_cnt      <= '0;
        end else begin
            if (psum_hs)
                col_cnt <= col_cnt + 1'b1;

            // A new product and the collector's accept may coincide; the new product wins.
            if (state == S_RUN && pix_hs)
                psum_valid_q <= 1'b1;
            else if (psum_hs)
                psum_valid_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        pe_mode  <= cfg_mode;
                        cols_q   <= cfg_cols;
                        col_cnt  <= '0;
                        px_cnt   <= '0;
                        fill_cnt <= '0;
                        lane     <= 2'd0;
                        state    <= (cfg_cols == '0) ? S_DONE : S_LOAD_W;
                    end
                end
                S_LOAD_W: state <= (KSIZE > 1) ? S_FILL : S_RUN;
                S_FILL: begin
                    if (pix_hs) begin
                        if (fill_cnt == FILL_W'(KSIZE - 2))
                            state <= S_RUN;
                        else
                            fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (pix_hs) begin
                        px_cnt <= px_cnt + 1'b1;
                        lane   <= (lane == 2'(CAST_LANES - 1)) ? 2'd0 : lane + 2'd1;
                        if (px_cnt == cols_q - 1'b1)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (psum_hs)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PE_ROW_CTRL_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else if (state == S_IDLE && start)
            stall_q <= '0;
        else if ((state == S_FILL || state == S_RUN) && !pix_hs && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_row_ctrl.sv
// Scoreboard bench for pe_row_ctrl: driver pushes per-pass expectations, negedge monitor checks them.
module tb_pe_row_ctrl;
    localparam int K  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    cfg_mode = 2'd0;
    logic [CW-1:0] cfg_cols = '0;
    logic          wgt_load, busy, done;
    logic [1:0]    pe_mode, cast_sel;
    logic [CW-1:0] col_cnt;
    logic [15:0]   stall_cnt;

    pe_row_ctrl_if bus();

    always #5 clk = ~clk;

    pe_row_ctrl #(.KSIZE(K), .CNT_W(CW), .CAST_LANES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_cols(cfg_cols),
        .bus(bus), .wgt_load(wgt_load), .pe_mode(pe_mode), .cast_sel(cast_sel),
        .col_cnt(col_cnt), .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    typedef struct { int cols; int mode; } pass_t;
    pass_t exp_pass[$];
    int    exp_cast[$];
    int    exp_col[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    pass_t cur;
    bit    in_pass = 0, prev_busy = 0, prev_bp = 0, expect_idle = 0;
    int    cyc, pix, psums, wl, last_pix, last_ps;

    always @(negedge clk) begin
        if (!rst) begin
            in_pass = 0; prev_busy = 0; prev_bp = 0; expect_idle = 0;
        end else begin
            if (expect_idle) begin
                chk("busy_after_done", busy, 0);
                expect_idle = 0;
            end
            if (!busy) chk("idle_cast_sel", cast_sel, 3);
            if (busy && !prev_busy) begin
                if (exp_pass.size() == 0) begin
                    chk("unexpected_pass", 1, 0);
                    in_pass = 0;
                end else begin
                    cur = exp_pass.pop_front();
                    in_pass = 1; cyc = 0; pix = 0; psums = 0; wl = 0;
                    last_pix = 0; last_ps = 0; prev_bp = 0;
                    chk("col_cnt_clear", col_cnt, 0);
                    chk("pe_mode", pe_mode, cur.mode);
                end
            end
            if (in_pass) begin
                cyc++;
                chk("pe_en", bus.pe_en, bus.pix_valid & bus.pix_ready);
                if (prev_bp) chk("psum_hold", bus.psum_valid, 1);
                if (bus.psum_valid && !bus.psum_ready) chk("bp_pix_ready", bus.pix_ready, 0);
                prev_bp = bus.psum_valid && !bus.psum_ready;
                if (wgt_load) begin
                    wl++;
                    chk("wgt_load_cycle", cyc, 1);
                end
                if (bus.pe_en) begin
                    if (exp_cast.size() == 0) chk("extra_pixel", 1, 0);
                    else chk("cast_sel", cast_sel, exp_cast.pop_front());
                    pix++;
                    last_pix = cyc;
                end
                if (bus.psum_valid && bus.psum_ready) begin
                    if (exp_col.size() == 0) chk("extra_psum", 1, 0);
                    else chk("psum_col", col_cnt, exp_col.pop_front());
                    psums++;
                    last_ps = cyc;
                end
                if (done) begin
                    chk("done_col_cnt", col_cnt, cur.cols);
                    chk("done_pixels", pix, (cur.cols == 0) ? 0 : cur.cols + K - 1);
                    chk("done_psums", psums, cur.cols);
                    chk("done_wgt_load", wl, (cur.cols != 0) ? 1 : 0);
                    chk("done_time", cyc, (cur.cols == 0) ? 1 : last_ps + 1);
`ifdef PE_ROW_CTRL_PERF_EN
                    // FILL+RUN span from cycle 2 to the last pixel; every non-handshake cycle there stalls.
                    chk("stall_cnt", stall_cnt, (cur.cols == 0) ? 0 : last_pix - 1 - pix);
`else
                    chk("stall_cnt", stall_cnt, 0);
`endif
                    in_pass = 0;
                    prev_bp = 0;
                    expect_idle = 1;
                end
            end else if (done) begin
                chk("unexpected_done", 1, 0);
            end
            prev_busy = busy;
        end
    end

    // ---------------- driver ----------------
    task automatic do_reset();
        rst = 1'b0;
        exp_pass.delete(); exp_cast.delete(); exp_col.delete();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wgt_load", wgt_load, 0);
        chk("rst_pix_ready", bus.pix_ready, 0);
        chk("rst_pe_en", bus.pe_en, 0);
        chk("rst_psum_valid", bus.psum_valid, 0);
        chk("rst_cast_sel", cast_sel, 3);
        chk("rst_pe_mode", pe_mode, 0);
        chk("rst_col_cnt", col_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_pass(input int cols, input int mode, input int pv_pct, input int pr_pct,
                            input int abort_ps, input int bp_hold, input bit noise);
        pass_t p;
        int hs = 0, n = 0, bp_left = bp_hold;
        bit fin = 0;
        p.cols = cols; p.mode = mode;
        exp_pass.push_back(p);
        for (int i = 0; i < ((cols == 0) ? 0 : cols + K - 1); i++)
            exp_cast.push_back((mode == 1 && i >= K - 1) ? (i - (K - 1)) % 3 : 3);
        for (int c = 0; c < cols; c++)
            exp_col.push_back(c);
        @(posedge clk); #1;
        cfg_cols = CW'(cols); cfg_mode = 2'(mode); start = 1'b1;
        while (n < 3000) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (fin) break;
            if (abort_ps > 0 && hs >= abort_ps) begin
                do_reset();
                return;
            end
            bus.pix_valid = ($urandom_range(99) < pv_pct);
            if (bp_left > 0 && bus.psum_valid) begin
                bus.psum_ready = 1'b0;
                bp_left--;
            end else begin
                bus.psum_ready = ($urandom_range(99) < pr_pct);
            end
            if (noise) begin
                start = ($urandom_range(3) == 0);
                cfg_cols = CW'($urandom);
                cfg_mode = 2'($urandom);
            end
            #1;
            if (bus.psum_valid && bus.psum_ready) hs++;
            if (done) begin
                fin = 1;
                if (noise) start = 1'b1;
            end
        end
        if (!fin) begin
            chk("pass_timeout", 0, 1);
            do_reset();
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.psum_ready = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();

        run_pass(4, 0, 100, 100, 0, 0, 0);
        chk("col_cnt_hold", col_cnt, 4);
        run_pass(5, 1, 100, 100, 0, 0, 0);
        run_pass(3, 0, 100, 100, 0, 4, 0);
`ifdef PE_ROW_CTRL_PERF_EN
        chk("bp_stall_cnt", stall_cnt, 4);
`else
        chk("bp_stall_cnt", stall_cnt, 0);
`endif
        run_pass(0, 2, 100, 100, 0, 0, 0);
        run_pass(8, 1, 100, 100, 2, 0, 0);
        run_pass(6, 1, 100, 100, 0, 0, 0);
        run_pass(9, 0, 100, 100, 0, 0, 1);
        run_pass(255, 1, 100, 100, 0, 0, 0);
        repeat (25)
            run_pass($urandom_range(0, 20), $urandom_range(0, 3), $urandom_range(30, 100),
                     $urandom_range(30, 100), 0, 0, 1'($urandom_range(0, 1)));
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_pass.size() + exp_cast.size() + exp_col.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
